// File: rtl/apmu_ibex_fetch_req_ctrl.sv
// Instruction-side fetch request controller: issues word-aligned bus requests with up to
// NUM_REQS in flight, throttled by FIFO fill, and forwards non-stale responses to the FIFO.
module apmu_ibex_fetch_req_ctrl #(
  parameter int NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_addr_i,
  output logic                busy_o,
  output logic                fifo_clear_o,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [31:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic [31:0]         instr_rdata_i,
  input  logic                instr_err_i,
  input  logic                instr_rvalid_i
);

  localparam int CNT_W = $clog2(NUM_REQS + 1);
  localparam int SUM_W = $clog2(2 * NUM_REQS + 1);

  typedef enum logic {IDLE, WAIT_GNT} state_e;

  state_e              state_q;
  logic [31:0]         fetch_addr_q;
  logic [31:0]         branch_addr_q;
  logic                pending_branch_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_pop;
  logic [NUM_REQS-1:0] discard_q;
  logic [NUM_REQS-1:0] discard_d;
  logic [SUM_W-1:0]    fill;
  logic                can_req;
  logic                grant;
  logic [31:0]         branch_target;

  always_comb begin
    fill = SUM_W'(cnt_q);
    for (int i = 0; i < NUM_REQS; i++) begin
      fill = fill + SUM_W'(fifo_busy_i[i]);
    end
  end

  assign can_req       = fill < SUM_W'(NUM_REQS);
  assign instr_req_o   = (state_q == WAIT_GNT) | (req_i & can_req);
  assign grant         = instr_req_o & instr_gnt_i;
  assign instr_addr_o  = {fetch_addr_q[31:2], 2'b00};
  assign branch_target = {branch_addr_i[31:2], 2'b00};
  assign cnt_pop       = cnt_q - CNT_W'(instr_rvalid_i);

  assign busy_o        = instr_req_o | (cnt_q != '0);
  assign fifo_clear_o  = branch_i;
  assign fifo_addr_o   = branch_addr_i;
  assign fifo_rdata_o  = instr_rdata_i;
  assign fifo_err_o    = instr_err_i;
  assign fifo_valid_o  = instr_rvalid_i & ~discard_q[0] & ~branch_i;

  // Bit 0 is the oldest outstanding response; a new grant lands just above the survivors.
  always_comb begin
    discard_d = instr_rvalid_i ? (discard_q >> 1) : discard_q;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (branch_i && (i < int'(cnt_pop))) begin
        discard_d[i] = 1'b1;
      end
      if (grant && (i == int'(cnt_pop))) begin
        discard_d[i] = branch_i | pending_branch_q;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= IDLE;
      fetch_addr_q     <= '0;
      branch_addr_q    <= '0;
      pending_branch_q <= 1'b0;
      cnt_q            <= '0;
      discard_q        <= '0;
    end else begin
      cnt_q     <= cnt_q + CNT_W'(grant) - CNT_W'(instr_rvalid_i);
      discard_q <= discard_d;

      case (state_q)
        IDLE:     if (instr_req_o && !instr_gnt_i) state_q <= WAIT_GNT;
        WAIT_GNT: if (instr_gnt_i) state_q <= IDLE;
        default:  state_q <= IDLE;
      endcase

      // A branch against an ungranted request must not disturb its address; defer the target.
      if (branch_i && instr_req_o && !instr_gnt_i) begin
        branch_addr_q    <= branch_target;
        pending_branch_q <= 1'b1;
      end else if (branch_i) begin
        fetch_addr_q     <= branch_target;
        pending_branch_q <= 1'b0;
      end else if (grant) begin
        fetch_addr_q     <= pending_branch_q ? branch_addr_q : fetch_addr_q + 32'd4;
        pending_branch_q <= 1'b0;
      end
    end
  end

  a_rvalid_without_outstanding: assert property (@(posedge clk_i) disable iff (rst_i)
    !(instr_rvalid_i && (cnt_q == '0)));
  a_grant_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
    !(grant && (cnt_q == CNT_W'(NUM_REQS))));
  a_push_into_full_fifo: assert property (@(posedge clk_i) disable iff (rst_i)
    !(fifo_valid_o && fifo_busy_i[NUM_REQS-1]));

endmodule

// File: tb/tb_apmu_ibex_fetch_req_ctrl.sv
// Bench for apmu_ibex_fetch_req_ctrl: reset-state vector table, a bus responder model with
// epoch-tagged requests, and a push scoreboard fed at stimulus time.
module tb_apmu_ibex_fetch_req_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        req_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        busy_o;
  logic        fifo_clear_o;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_err_o;
  logic [1:0]  fifo_busy_i = '0;
  logic        instr_req_o;
  logic        instr_gnt_i = 1'b0;
  logic [31:0] instr_addr_o;
  logic [31:0] instr_rdata_i = '0;
  logic        instr_err_i = 1'b0;
  logic        instr_rvalid_i = 1'b0;

  apmu_ibex_fetch_req_ctrl #(.NUM_REQS(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .branch_i(branch_i),
    .branch_addr_i(branch_addr_i), .busy_o(busy_o), .fifo_clear_o(fifo_clear_o),
    .fifo_valid_o(fifo_valid_o), .fifo_addr_o(fifo_addr_o), .fifo_rdata_o(fifo_rdata_o),
    .fifo_err_o(fifo_err_o), .fifo_busy_i(fifo_busy_i), .instr_req_o(instr_req_o),
    .instr_gnt_i(instr_gnt_i), .instr_addr_o(instr_addr_o), .instr_rdata_i(instr_rdata_i),
    .instr_err_i(instr_err_i), .instr_rvalid_i(instr_rvalid_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          tag;
    int          ready;
  } bus_t;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    logic        req;
    logic [1:0]  busy;
    logic        br;
    logic [31:0] baddr;
    logic        exp_req;
    logic        exp_busy;
    logic        exp_clr;
  } vec_t;

  bus_t        bus_q[$];
  exp_t        exp_q[$];
  logic [31:0] exp_addr_q[$];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int epoch = 0;
  int n_grants = 0;
  int n_push = 0;
  int req_tag = 0;
  logic        req_active = 1'b0;
  logic [31:0] held_addr = '0;

  logic        drv_req = 1'b0, drv_gnt = 1'b0, drv_branch = 1'b0;
  logic        resp_en = 1'b0, err_en = 1'b0;
  logic [1:0]  drv_busy = '0;
  logic [31:0] drv_baddr = '0;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Called at posedge+1: drive one cycle, sample at the falling edge, update the model.
  task automatic run_cycle();
    exp_t e;
    req_i = drv_req; instr_gnt_i = drv_gnt; fifo_busy_i = drv_busy;
    branch_i = drv_branch; branch_addr_i = drv_baddr;
    instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
    if (resp_en && bus_q.size() > 0 && bus_q[0].ready <= cyc) begin
      instr_rvalid_i = 1'b1;
      instr_rdata_i  = bus_q[0].data;
      instr_err_i    = err_en;
      if (bus_q[0].tag == epoch && !drv_branch) exp_q.push_back('{bus_q[0].data, err_en});
    end
    #4;
    if (instr_rvalid_i || fifo_valid_o) begin
      chk("push_valid", 32'(fifo_valid_o), 32'(exp_q.size() != 0));
      if (fifo_valid_o && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("push_data", fifo_rdata_o, e.data);
        chk("push_err", 32'(fifo_err_o), 32'(e.err));
        n_push++;
        $display("cycle %0d push data=%h err=%b", cyc, fifo_rdata_o, fifo_err_o);
      end
      exp_q.delete();
    end
    if (req_active) begin
      chk("req_held", 32'(instr_req_o), 32'd1);
      chk("addr_stable", instr_addr_o, held_addr);
    end else if (instr_req_o) begin
      req_active = 1'b1;
      req_tag    = epoch;
      held_addr  = instr_addr_o;
    end
    if (instr_req_o && instr_gnt_i) begin
      bus_q.push_back('{instr_addr_o, data_of(instr_addr_o), req_tag, cyc + 1});
      n_grants++;
      if (exp_addr_q.size() > 0) chk("grant_addr", instr_addr_o, exp_addr_q.pop_front());
      req_active = 1'b0;
    end
    if (instr_rvalid_i) void'(bus_q.pop_front());
    if (branch_i) epoch++;
    cyc++;
    @(posedge clk_i); #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  // Asserted at posedge+1: outputs must clear before any clock edge.
  task automatic do_reset();
    drv_req = 0; drv_gnt = 0; drv_branch = 0; drv_busy = '0; drv_baddr = '0;
    resp_en = 0; err_en = 0;
    req_i = 0; instr_gnt_i = 0; branch_i = 0; fifo_busy_i = '0; instr_rvalid_i = 0;
    rst_i = 1'b1;
    #1;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_req", 32'(instr_req_o), 32'd0);
    chk("rst_addr", instr_addr_o, 32'd0);
    bus_q.delete(); exp_q.delete(); exp_addr_q.delete();
    epoch = 0; req_active = 1'b0; n_grants = 0; n_push = 0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 2'b00, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 2'b00, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{1'b1, 2'b01, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 2'b10, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 2'b11, 1'b0, 32'h0000_0000, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 2'b00, 1'b1, 32'h0000_1236, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b1, 2'b11, 1'b1, 32'hDEAD_BEEE, 1'b0, 1'b0, 1'b1};

    @(posedge clk_i); #1;
    // Held in reset: combinational outputs are a pure function of inputs and reset state.
    for (int i = 0; i < 7; i++) begin
      req_i = vecs[i].req; fifo_busy_i = vecs[i].busy;
      branch_i = vecs[i].br; branch_addr_i = vecs[i].baddr;
      #1;
      chk($sformatf("vec%0d_req", i), 32'(instr_req_o), 32'(vecs[i].exp_req));
      chk($sformatf("vec%0d_busy", i), 32'(busy_o), 32'(vecs[i].exp_busy));
      chk($sformatf("vec%0d_clear", i), 32'(fifo_clear_o), 32'(vecs[i].exp_clr));
      chk($sformatf("vec%0d_faddr", i), fifo_addr_o, vecs[i].baddr);
      chk($sformatf("vec%0d_iaddr", i), instr_addr_o, 32'd0);
      chk($sformatf("vec%0d_fvalid", i), 32'(fifo_valid_o), 32'd0);
    end
    @(posedge clk_i); #1;

    // 1: branch to 0x100 with streaming grants and 1-cycle responses
    do_reset();
    exp_addr_q = '{32'h0, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    drv_req = 1; drv_gnt = 1; resp_en = 1; drv_branch = 1; drv_baddr = 32'h100;
    run(1);
    drv_branch = 0;
    run(5);
    drv_req = 0;
    run(3);
    chk("t1_addr_seq_done", 32'(exp_addr_q.size()), 32'd0);
    chk("t1_push_count", 32'(n_push), 32'(n_grants - 1));
    chk("t1_idle", 32'(busy_o), 32'd0);

    // 2: responses withheld -> exactly NUM_REQS grants
    do_reset();
    drv_req = 1; drv_gnt = 1;
    run(4);
    chk("t2_grants", 32'(n_grants), 32'd2);
    chk("t2_req_off", 32'(instr_req_o), 32'd0);
    chk("t2_busy", 32'(busy_o), 32'd1);
    drv_req = 0; resp_en = 1;
    run(4);
    chk("t2_push_count", 32'(n_push), 32'd2);
    chk("t2_idle", 32'(busy_o), 32'd0);

    // 3: FIFO occupancy throttles requests
    do_reset();
    drv_busy = 2'b11; drv_req = 1; drv_gnt = 1;
    run(3);
    chk("t3_no_grant", 32'(n_grants), 32'd0);
    chk("t3_req_off", 32'(instr_req_o), 32'd0);
    drv_busy = 2'b01;
    run(3);
    chk("t3_one_grant", 32'(n_grants), 32'd1);
    drv_req = 0; resp_en = 1;
    run(3);
    chk("t3_push_count", 32'(n_push), 32'd1);

    // 4: branch to 0x202 with two responses outstanding
    do_reset();
    exp_addr_q = '{32'h0, 32'h4, 32'h200, 32'h204};
    drv_req = 1; drv_gnt = 1;
    run(2);
    drv_branch = 1; drv_baddr = 32'h202;
    run(1);
    drv_branch = 0; resp_en = 1;
    run(3);
    drv_req = 0;
    run(4);
    chk("t4_addr_seq_done", 32'(exp_addr_q.size()), 32'd0);
    chk("t4_push_count", 32'(n_push), 32'(n_grants - 2));

    // 5: branch while a request waits for grant
    do_reset();
    exp_addr_q = '{32'h0, 32'h300};
    drv_req = 1; drv_gnt = 0; resp_en = 1;
    run(1);
    drv_branch = 1; drv_baddr = 32'h300;
    run(1);
    drv_branch = 0;
    run(1);
    drv_gnt = 1;
    run(2);
    drv_req = 0;
    run(3);
    chk("t5_addr_seq_done", 32'(exp_addr_q.size()), 32'd0);
    chk("t5_push_count", 32'(n_push), 32'd1);

    // 6: error response is pushed with its error flag
    do_reset();
    drv_req = 1; drv_gnt = 1; resp_en = 1;
    run(1);
    drv_req = 0; err_en = 1;
    run(1);
    chk("t6_push_count", 32'(n_push), 32'd1);
    chk("t6_count_dec", 32'(busy_o), 32'd0);

    // 7: asynchronous reset with two responses outstanding
    do_reset();
    exp_addr_q = '{32'h0, 32'h4};
    drv_req = 1; drv_gnt = 1;
    run(2);
    chk("t7_busy_before", 32'(busy_o), 32'd1);
    do_reset();
    drv_req = 1; drv_gnt = 1; resp_en = 1;
    exp_addr_q = '{32'h0};
    run(2);
    drv_req = 0;
    run(2);
    chk("t7_restart", 32'(exp_addr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
